// File: rtl/edit_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edit_field_ctrl
// Purpose  : Edit-mode controller for six RTC time/date fields. Steers a
//            shared up/down data counter (limit, enable, clear), captures
//            the counted value per field and, on leaving edit mode, writes
//            every field to the RTC register interface as BCD over a
//            req/ack handshake with timeout.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            btn_prog/btn_left/btn_right  - level buttons (edge detected here)
//            cnt_val                      - current data counter value
//            cnt_wr/cnt_en/cnt_limit      - counter control (clear, enable, wrap)
//            field_sel                    - active field 0..5
//            wr_req/wr_ack/wr_addr/wr_data- RTC register write handshake
//            busy/done/err                - status (done/err are 1-cycle pulses)
// Revision : 1.0 - initial release
// ============================================================================
module edit_field_ctrl #(
    parameter logic [7:0]  ADDR_BASE = 8'h21,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_prog,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [6:0] cnt_val,
    output logic       cnt_wr,
    output logic       cnt_en,
    output logic [6:0] cnt_limit,
    output logic [2:0] field_sel,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] c_WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] c_LAST_FIELD = 3'd5;
    localparam logic [2:0] c_F_DIA      = 3'd3;
    localparam logic [2:0] c_F_MES      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDIT   = 3'd1,
        S_SWITCH = 3'd2,
        S_COMMIT = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sel, w_sel_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [7:0] r_wait;
    logic       r_prog_q, r_left_q, r_right_q;
    logic       w_prog_edge, w_left_edge, w_right_edge;
    logic       w_capture, w_done_nxt, w_err_nxt;
    logic [6:0] w_cap_val;
    logic [6:0] w_commit_val;
    logic [6:0] r_field [0:5];
    logic       r_cnt_wr, r_cnt_en, r_done, r_err;

    assign w_prog_edge  = btn_prog  & ~r_prog_q;
    assign w_left_edge  = btn_left  & ~r_left_q;
    assign w_right_edge = btn_right & ~r_right_q;

    // Day and month have no zero; a zero count is promoted to 1.
    assign w_cap_val = ((r_sel == c_F_DIA || r_sel == c_F_MES) && cnt_val == 7'd0)
                       ? 7'd1 : cnt_val;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_prog_edge) begin
                    w_state_nxt = S_EDIT;
                    w_sel_nxt   = 3'd0;
                end
            end
            S_EDIT: begin
                if (w_prog_edge) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_COMMIT;
                    w_idx_nxt   = 3'd0;
                end else if (w_right_edge && !w_left_edge) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SWITCH;
                    w_sel_nxt   = (r_sel == c_LAST_FIELD) ? 3'd0 : r_sel + 3'd1;
                end else if (w_left_edge && !w_right_edge) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SWITCH;
                    w_sel_nxt   = (r_sel == 3'd0) ? c_LAST_FIELD : r_sel - 3'd1;
                end
            end
            S_SWITCH: begin
                // One cycle with the counter held clear, so the new field
                // always starts counting from zero.
                w_state_nxt = S_EDIT;
            end
            S_COMMIT: begin
                if (wr_ack) begin
                    if (r_idx == c_LAST_FIELD) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_COMMIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= 3'd0;
            r_idx     <= 3'd0;
            r_wait    <= 8'd0;
            r_prog_q  <= 1'b0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
            r_cnt_wr  <= 1'b1;
            r_cnt_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_field[i] <= (i == 3 || i == 4) ? 7'd1 : 7'd0;
            end
        end else begin
            r_sel     <= w_sel_nxt;
            r_idx     <= w_idx_nxt;
            r_prog_q  <= btn_prog;
            r_left_q  <= btn_left;
            r_right_q <= btn_right;
            r_cnt_wr  <= (w_state_nxt != S_EDIT);
            r_cnt_en  <= (w_state_nxt == S_EDIT);
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            if (w_capture) begin
                r_field[r_sel] <= w_cap_val;
            end
            // Counts cycles of the current request only; any new request
            // (entry from EDIT or GAP) starts again from zero.
            if (r_state == S_COMMIT && w_state_nxt == S_COMMIT) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        case (r_sel)
            3'd0:    cnt_limit = 7'd59;
            3'd1:    cnt_limit = 7'd59;
            3'd2:    cnt_limit = 7'd23;
            3'd3:    cnt_limit = 7'd31;
            3'd4:    cnt_limit = 7'd12;
            3'd5:    cnt_limit = 7'd99;
            default: cnt_limit = 7'd0;
        endcase
    end

    assign w_commit_val = r_field[r_idx];

    // Address and data are derived from registers that do not move while
    // a request is outstanding, so they stay stable for the whole request.
    assign wr_req  = (r_state == S_COMMIT);
    assign wr_addr = wr_req ? (ADDR_BASE + {5'd0, r_idx}) : 8'd0;
    assign wr_data = !wr_req                ? 8'd0  :
                     (w_commit_val > 7'd99) ? 8'h99 :
                     {4'(w_commit_val / 7'd10), 4'(w_commit_val % 7'd10)};

    assign field_sel = r_sel;
    assign cnt_wr    = r_cnt_wr;
    assign cnt_en    = r_cnt_en;
    assign busy      = (r_state == S_SWITCH) || (r_state == S_COMMIT) || (r_state == S_GAP);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
